// File: rtl/uart_rx_frame_parser.sv
// Frame parser for the UART receive path: HDR0 HDR1 LEN PAYLOAD[LEN] CHK.
// A checked payload is buffered and then drained over a valid/ready byte port.
module uart_rx_frame_parser #(
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [15:0] TIMEOUT_CYC = 16'd8680
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       pl_last,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LAST  = TIMEOUT_CYC - 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LEN   = 3'd2,
    ST_PAY   = 3'd3,
    ST_CHK   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  state_t           state_q;
  logic [7:0]       len_q;
  logic [7:0]       sum_q;
  logic [7:0]       idx_q;
  logic [7:0]       rd_idx_q;
  logic [15:0]      tmo_q;
  logic [7:0]       buf_q [MAX_LEN];
  logic [7:0]       pl_data_q;
  logic             pl_valid_q;
  logic             pl_last_q;
  logic [7:0]       frame_len_q;
  logic             frame_ok_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;
  logic             busy_q;

  logic [7:0]       rd_nxt_s;
  logic [7:0]       len_m1_s;
  logic             tmo_hit_s;
  logic [IDX_W-1:0] wr_ptr_s;
  logic [IDX_W-1:0] rd_ptr_nxt_s;

  // Running checksum is a plain modulo-256 byte sum seeded with LEN.
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

  assign rd_nxt_s     = rd_idx_q + 8'd1;
  assign len_m1_s     = len_q - 8'd1;
  assign tmo_hit_s    = (tmo_q == TMO_LAST);
  assign wr_ptr_s     = idx_q[IDX_W-1:0];
  assign rd_ptr_nxt_s = rd_nxt_s[IDX_W-1:0];

  // Frame FSM, payload buffer, inter-byte timeout and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      rd_idx_q    <= 8'd0;
      tmo_q       <= 16'd0;
      pl_data_q   <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      frame_len_q <= 8'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      busy_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        buf_q[i] <= 8'd0;
      end
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmo_q <= 16'd0;
          if (rx_en && (rx_data == HDR0)) begin
            state_q <= ST_HDR;
            busy_q  <= 1'b1;
          end
        end
        ST_HDR, ST_LEN, ST_PAY, ST_CHK: begin
          // Timeout takes priority over a byte arriving on the same cycle.
          if (tmo_hit_s) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            tmo_q       <= 16'd0;
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd3;
          end else if (rx_en) begin
            tmo_q <= 16'd0;
            case (state_q)
              ST_HDR: begin
                if (rx_data == HDR1) begin
                  state_q <= ST_LEN;
                end else if (rx_data != HDR0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                end
              end
              ST_LEN: begin
                if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd1;
                end else begin
                  len_q   <= rx_data;
                  sum_q   <= rx_data;
                  idx_q   <= 8'd0;
                  state_q <= ST_PAY;
                end
              end
              ST_PAY: begin
                buf_q[wr_ptr_s] <= rx_data;
                sum_q           <= chk_add(sum_q, rx_data);
                if (idx_q == len_m1_s) begin
                  state_q <= ST_CHK;
                end else begin
                  idx_q <= idx_q + 8'd1;
                end
              end
              ST_CHK: begin
                if (rx_data == sum_q) begin
                  frame_ok_q  <= 1'b1;
                  frame_len_q <= len_q;
                  rd_idx_q    <= 8'd0;
                  pl_data_q   <= buf_q[{IDX_W{1'b0}}];
                  pl_last_q   <= (len_q == 8'd1);
                  pl_valid_q  <= 1'b1;
                  state_q     <= ST_DRAIN;
                end else begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd2;
                end
              end
              default: begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          tmo_q <= 16'd0;
          // Bytes arriving while draining cannot be buffered; flag and drop them.
          if (rx_en) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'd0;
          end
          if (pl_valid_q && pl_ready) begin
            if (pl_last_q) begin
              pl_valid_q <= 1'b0;
              pl_last_q  <= 1'b0;
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
            end else begin
              rd_idx_q  <= rd_nxt_s;
              pl_data_q <= buf_q[rd_ptr_nxt_s];
              pl_last_q <= (rd_nxt_s == len_m1_s);
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          pl_valid_q <= 1'b0;
          pl_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_last   = pl_last_q;
  assign frame_len = frame_len_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: directed frames push expected
// frame_ok / frame_err / payload events, a negedge monitor pops and compares.
module tb_uart_rx_frame_parser;

  localparam int TMO = 8680;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_en = 1'b0;
  logic       pl_ready = 1'b1;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic [7:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  typedef struct {
    int         kind;   // 0 frame_ok(len), 1 frame_err(code), 2 payload byte
    logic [7:0] val;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  uart_rx_frame_parser dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_en(rx_en),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_last(pl_last),
    .frame_len(frame_len), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push(input int k, input logic [7:0] v, input logic l);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input logic [7:0] v, input logic l, input string nm);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event val=%02h last=%0b with empty scoreboard", nm, v, l);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v || e.last != l) begin
        fails++;
        $display("FAIL %s: got kind=%0d val=%02h last=%0b, expected kind=%0d val=%02h last=%0b",
                 nm, k, v, l, e.kind, e.val, e.last);
      end
    end
  endtask

  // Monitor: outputs sampled on the falling edge, inputs change only just after rising edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok)             pop_cmp(0, frame_len, 1'b0, "frame_ok");
      if (frame_err)            pop_cmp(1, {6'd0, err_code}, 1'b0, "frame_err");
      if (pl_valid && pl_ready) pop_cmp(2, pl_data, pl_last, "payload");
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_en   = 1'b1;
    @(posedge clk); #1;
    rx_en   = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while (sb.size() != 0 && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events never seen, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] f[$];
    int         cnt;
    logic       held_ok;

    // Reset state
    #12;
    check("reset_outputs", 32'({pl_data, pl_valid, pl_last, frame_len, frame_ok,
                                frame_err, err_code, busy}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: good frame, checksum 03+11+22+33 = 69
    push(0, 8'h03, 1'b0);
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(f);
    wait_done("t1_good");
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: same frame with wrong checksum
    push(1, 8'd2, 1'b0);
    f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    send_seq(f);
    wait_done("t2_badchk");
    check("t2_busy_low", 32'(busy), 32'd0);
    check("t2_no_valid", 32'(pl_valid), 32'd0);
    check("t2_code_held", 32'(err_code), 32'd2);

    // 3: LEN 0 and LEN 17, then a max-length (16) frame 10..1F, checksum 10+sum(10..1F) = 88
    push(1, 8'd1, 1'b0);
    push(1, 8'd1, 1'b0);
    f = '{8'h55, 8'hAA, 8'h00, 8'h55, 8'hAA, 8'h11};
    send_seq(f);
    push(0, 8'd16, 1'b0);
    for (int i = 0; i < 16; i++) push(2, 8'(8'h10 + i), (i == 15));
    f = '{8'h55, 8'hAA, 8'h10};
    for (int i = 0; i < 16; i++) f.push_back(8'(8'h10 + i));
    f.push_back(8'h88);
    send_seq(f);
    wait_done("t3_len");
    check("t3_frame_len", 32'(frame_len), 32'd16);

    // 4: stall after one payload byte -> timeout exactly TMO cycles after the last byte
    push(1, 8'd3, 1'b0);
    f = '{8'h55, 8'hAA, 8'h02};
    send_seq(f);
    @(posedge clk); #1;
    rx_data = 8'h11;
    rx_en   = 1'b1;
    @(posedge clk); #1;
    rx_en   = 1'b0;
    cnt = 0;
    while (!frame_err && cnt < 20000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("t4_timeout_latency", 32'(cnt), 32'(TMO));
    wait_done("t4_timeout");
    check("t4_busy_idle", 32'(busy), 32'd0);
    push(0, 8'h03, 1'b0);
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(f);
    wait_done("t4_after");

    // 5: noise then resync on repeated HDR0; checksum 01+FF wraps to 00
    push(0, 8'h01, 1'b0);
    push(2, 8'hFF, 1'b1);
    f = '{8'h12, 8'h34, 8'h55, 8'h55, 8'hAA, 8'h01, 8'hFF, 8'h00};
    send_seq(f);
    wait_done("t5_resync");

    // 6a: backpressure with a byte dropped during drain; checksum 04+01+02+03+04 = 0E
    pl_ready = 1'b0;
    push(0, 8'h04, 1'b0);
    push(1, 8'd0, 1'b0);
    push(2, 8'h01, 1'b0); push(2, 8'h02, 1'b0); push(2, 8'h03, 1'b0); push(2, 8'h04, 1'b1);
    f = '{8'h55, 8'hAA, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
    send_seq(f);
    held_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) send(8'h7E);
      @(posedge clk); #1;
      if (!(pl_valid && pl_data == 8'h01 && !pl_last && busy)) held_ok = 1'b0;
    end
    check("t6_stall_hold", 32'(held_ok), 32'd1);
    check("t6_drop_code", 32'(err_code), 32'd0);
    pl_ready = 1'b1;
    wait_done("t6_drain");

    // 6b: asynchronous reset mid-payload clears everything, then a good frame
    f = '{8'h55, 8'hAA, 8'h03, 8'h11};
    send_seq(f);
    check("t6_busy_mid", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", 32'({pl_data, pl_valid, pl_last, frame_len, frame_ok,
                                   frame_err, err_code, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(0, 8'h03, 1'b0);
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq(f);
    wait_done("t6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
